// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - queued ALU operand/control initiator with in-order valid/ready responses
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_CODE   = 9
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [CTRL_WIDTH-1:0] ReqCtrl,
  input  logic [DATA_WIDTH-1:0] ReqA,
  input  logic [DATA_WIDTH-1:0] ReqB,
  output logic [CTRL_WIDTH-1:0] ALUControl,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  input  logic                  Zero,
  output logic                  RspValid,
  input  logic                  RspReady,
  output logic [DATA_WIDTH-1:0] RspResult,
  output logic                  RspZero,
  output logic [CTRL_WIDTH-1:0] RspCtrl,
  output logic                  RspErr,
  output logic                  Busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  logic [CTRL_WIDTH-1:0] fifo_ctrl_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_a_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_b_q    [FIFO_DEPTH];

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CTRL_WIDTH-1:0] alu_ctrl_q, alu_ctrl_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  err_q, err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_zero_q, rsp_zero_d;
  logic [CTRL_WIDTH-1:0] rsp_ctrl_q, rsp_ctrl_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;
  logic                  full, push, pop;

  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  assign push = ReqValid && !full;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    alu_ctrl_d   = alu_ctrl_q;
    a_d          = a_q;
    b_d          = b_q;
    err_d        = err_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ctrl_d   = rsp_ctrl_q;
    rsp_err_d    = rsp_err_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          alu_ctrl_d = fifo_ctrl_q[rd_ptr_q];
          a_d        = fifo_a_q[rd_ptr_q];
          b_d        = fifo_b_q[rd_ptr_q];
          err_d      = fifo_ctrl_q[rd_ptr_q] > CTRL_WIDTH'(MAX_CODE);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_CAPTURE;
      S_CAPTURE: begin
        // An illegal code never trusts the ALU: report a forced zero result.
        rsp_result_d = err_q ? '0 : ALUResult;
        rsp_zero_d   = err_q ? 1'b1 : Zero;
        rsp_ctrl_d   = alu_ctrl_q;
        rsp_err_d    = err_q;
        rsp_valid_d  = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (RspReady) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_ctrl_q[wr_ptr_q] <= ReqCtrl;
      fifo_a_q[wr_ptr_q]    <= ReqA;
      fifo_b_q[wr_ptr_q]    <= ReqB;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      alu_ctrl_q   <= '0;
      a_q          <= '0;
      b_q          <= '0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_ctrl_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      alu_ctrl_q   <= alu_ctrl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ctrl_q   <= rsp_ctrl_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign ReqReady   = !full;
  assign ALUControl = alu_ctrl_q;
  assign A          = a_q;
  assign B          = b_q;
  assign RspValid   = rsp_valid_q;
  assign RspResult  = rsp_result_q;
  assign RspZero    = rsp_zero_q;
  assign RspCtrl    = rsp_ctrl_q;
  assign RspErr     = rsp_err_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural ALU
module tb_alu_op_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        ReqValid;
  logic        ReqReady;
  logic [3:0]  ReqCtrl;
  logic [31:0] ReqA, ReqB;
  logic [3:0]  ALUControl;
  logic [31:0] A, B;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspResult;
  logic        RspZero;
  logic [3:0]  RspCtrl;
  logic        RspErr;
  logic        Busy;

  alu_op_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqCtrl(ReqCtrl), .ReqA(ReqA), .ReqB(ReqB),
    .ALUControl(ALUControl), .A(A), .B(B), .ALUResult(ALUResult), .Zero(Zero),
    .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult), .RspZero(RspZero),
    .RspCtrl(RspCtrl), .RspErr(RspErr), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Illegal codes produce a non-zero garbage value so the forced-zero path is visible.
  always_comb begin
    case (ALUControl)
      4'd0:    ALUResult = A + B;
      4'd1:    ALUResult = A - B;
      4'd2:    ALUResult = A * B;
      4'd3:    ALUResult = A & B;
      4'd4:    ALUResult = A | B;
      4'd5:    ALUResult = ~(A | B);
      4'd6:    ALUResult = A ^ B;
      4'd7:    ALUResult = A << B[4:0];
      4'd8:    ALUResult = A >> B[4:0];
      4'd9:    ALUResult = {31'd0, $signed(A) < $signed(B)};
      default: ALUResult = 32'hDEAD_BEEF;
    endcase
    Zero = (ALUResult == 32'd0);
  end

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] result;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_rsp = 0;
  int   n_exp = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n && RspValid && RspReady) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_rsp", RspValid, 0);
        end else begin
          e = sb.pop_front();
          n_rsp++;
          check_eq("rsp_result", RspResult, e.result);
          check_eq("rsp_zero", RspZero, e.zero);
          check_eq("rsp_ctrl", RspCtrl, e.ctrl);
          check_eq("rsp_err", RspErr, e.err);
        end
      end
    end
  end

  task automatic push_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic zero, input logic err);
    exp_t e;
    int   waited = 0;
    bit   done = 0;
    ReqValid = 1'b1;
    ReqCtrl  = ctrl;
    ReqA     = a;
    ReqB     = b;
    while (!done) begin
      @(negedge Clk);
      if (ReqReady) begin
        e.ctrl = ctrl; e.result = res; e.zero = zero; e.err = err;
        sb.push_back(e);
        n_exp++;
        done = 1;
      end else if (++waited > 200) begin
        check_eq("push_timeout", ReqReady, 1);
        done = 1;
      end
      @(posedge Clk); #1;
    end
    ReqValid = 1'b0;
  endtask

  task automatic push_legal(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res);
    push_op(ctrl, a, b, res, res == 32'd0, 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge Clk);
      t++;
    end
    check_eq(tag, sb.size(), 0);
    @(posedge Clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctrl"}, ALUControl, 0);
    check_eq({tag, "_a"}, A, 0);
    check_eq({tag, "_b"}, B, 0);
    check_eq({tag, "_rsp_result"}, RspResult, 0);
    check_eq({tag, "_rsp_ctrl"}, RspCtrl, 0);
    check_eq({tag, "_rsp_zero"}, RspZero, 0);
    check_eq({tag, "_rsp_err"}, RspErr, 0);
    check_eq({tag, "_rsp_valid"}, RspValid, 0);
    check_eq({tag, "_busy"}, Busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int t;
    logic [31:0] a, b, held;
    Rst_n = 1'b0; ReqValid = 1'b0; ReqCtrl = '0; ReqA = '0; ReqB = '0; RspReady = 1'b1;

    // reset and single add with latency
    repeat (3) @(negedge Clk);
    check_all_zero("reset");
    @(posedge Clk); #1; Rst_n = 1'b1;
    @(negedge Clk);
    check_eq("req_ready_after_reset", ReqReady, 1);
    @(posedge Clk); #1;
    push_legal(4'd0, 32'd4, 32'd9, 32'd13);
    @(negedge Clk); check_eq("lat_e0_valid", RspValid, 0); check_eq("lat_busy", Busy, 1);
    @(negedge Clk); check_eq("lat_e1_valid", RspValid, 0);
    @(negedge Clk); check_eq("lat_e2_valid", RspValid, 0);
    @(negedge Clk); check_eq("lat_e3_valid", RspValid, 1);
    wait_drain("drain_add");
    @(negedge Clk); check_eq("idle_busy", Busy, 0);
    @(posedge Clk); #1;

    // ordered burst
    push_legal(4'd1, 32'd9, 32'd2, 32'd7);
    push_legal(4'd2, 32'd3, 32'd5, 32'd15);
    push_legal(4'd3, 32'h0000_FFFF, 32'h00FF_00FF, 32'h0000_00FF);
    push_legal(4'd9, 32'd15, 32'd7, 32'd0);
    wait_drain("drain_burst");

    // full and backpressure
    RspReady = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      a = 32'h0F0F_0F0F + 32'(i);
      b = 32'h00FF_0000 | 32'(i * 3);
      ReqValid = 1'b1; ReqCtrl = 4'd6; ReqA = a; ReqB = b;
      @(negedge Clk);
      if (ReqReady) begin
        exp_t e;
        e.ctrl = 4'd6; e.result = a ^ b; e.zero = ((a ^ b) == 32'd0); e.err = 1'b0;
        sb.push_back(e);
        n_exp++;
        acc++;
      end
      @(posedge Clk); #1;
    end
    ReqValid = 1'b0;
    check_eq("bp_accepts", acc, 5);
    @(negedge Clk);
    check_eq("bp_req_ready_low", ReqReady, 0);
    check_eq("bp_first_valid", RspValid, 1);
    held = (32'h0F0F_0F0F) ^ (32'h00FF_0000);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check_eq("bp_hold_valid", RspValid, 1);
      check_eq("bp_hold_result", RspResult, held);
    end
    @(posedge Clk); #1; RspReady = 1'b1;
    wait_drain("drain_bp");

    // illegal code, then a legal op
    push_op(4'd12, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);
    push_legal(4'd0, 32'd100, 32'd23, 32'd123);
    wait_drain("drain_illegal");

    // reset while ISSUE with two ops queued
    RspReady = 1'b0;
    push_legal(4'd0, 32'd1, 32'd2, 32'd3);
    push_legal(4'd0, 32'd5, 32'd6, 32'd11);
    push_legal(4'd0, 32'd7, 32'd8, 32'd15);
    push_legal(4'd0, 32'd9, 32'd10, 32'd19);
    t = 0;
    while (!RspValid && t < 50) begin @(posedge Clk); #1; t++; end
    check_eq("rst_mid_first_valid", RspValid, 1);
    RspReady = 1'b1;
    @(posedge Clk);
    @(posedge Clk); #2;
    check_eq("rst_mid_busy_before", Busy, 1);
    Rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", RspValid, 0);
    check_eq("rst_mid_busy", Busy, 0);
    check_eq("rst_mid_ctrl", ALUControl, 0);
    n_exp -= sb.size();
    sb.delete();
    @(posedge Clk); @(posedge Clk); #1; Rst_n = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge Clk);
    check_eq("rst_mid_no_stale_busy", Busy, 0);
    @(posedge Clk); #1;

    // pointer wrap
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) push_legal(4'd7, 32'd7, 32'd2, 32'd28);
      else            push_legal(4'd8, 32'd31, 32'd2, 32'd7);
    end
    wait_drain("drain_wrap");

    check_eq("rsp_total", n_rsp, n_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU operand/control interface: drives ALUControl, A and B into the combinational ALU and captures ALUResult and Zero.
- Upstream producers enqueue operation requests over a valid/ready port into an internal FIFO.
- The block issues one operation at a time, registers the ALU outputs, and presents each result on a valid/ready response port in request order.
- Used for bring-up, self-test and multi-cycle datapath sequencing around the ALU.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- CTRL_WIDTH, 4, ALU control code width.
- FIFO_DEPTH, 4, request FIFO entries; power of two, ≥2.
- MAX_CODE, 9, highest legal ALU control code (0 add, 1 sub, 2 mul, 3 and, 4 or, 5 nor, 6 xor, 7 sll, 8 srl, 9 slt).

Ports:
- Clk  in  1  rising-edge clock.
- Rst_n  in  1  asynchronous active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  FIFO can accept; equals !full.
- ReqCtrl  in  CTRL_WIDTH  operation code.
- ReqA  in  DATA_WIDTH  operand A.
- ReqB  in  DATA_WIDTH  operand B.
- ALUControl  out  CTRL_WIDTH  registered control to ALU.
- A  out  DATA_WIDTH  registered operand A to ALU.
- B  out  DATA_WIDTH  registered operand B to ALU.
- ALUResult  in  DATA_WIDTH  ALU result (combinational from A/B/ALUControl).
- Zero  in  1  ALU zero flag.
- RspValid  out  1  response present.
- RspReady  in  1  consumer accepts response.
- RspResult  out  DATA_WIDTH  captured result.
- RspZero  out  1  captured zero flag.
- RspCtrl  out  CTRL_WIDTH  code of the op that produced this response.
- RspErr  out  1  op code > MAX_CODE.
- Busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset (Rst_n=0, asynchronous):
  - FIFO pointers and count cleared; FSM to IDLE.
  - ALUControl, A, B, RspResult, RspCtrl, RspZero, RspErr, RspValid, Busy all 0.
  - ReqReady=1 once reset is released.
  - Reset mid-operation discards all queued and in-flight ops; no response is produced for them.
- FIFO:
  - Push when ReqValid && ReqReady. Pop when FSM in IDLE and FIFO non-empty.
  - Simultaneous push and pop when full is not allowed, since ReqReady=0 when full.
  - Simultaneous push and pop at other counts leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into ALUControl/A/B (plus an err flag if code > MAX_CODE) → ISSUE; else stay.
  - ISSUE: ALU inputs stable for one cycle → CAPTURE.
  - CAPTURE: register RspResult ← ALUResult, RspZero ← Zero, RspCtrl ← ALUControl, RspErr ← err, RspValid ← 1 → RESP.
  - Illegal op: on the CAPTURE edge, RspResult ← 0, RspZero ← 1, RspErr ← 1; ALU outputs ignored.
  - RESP: hold all Rsp* stable while RspValid && !RspReady. On RspReady, RspValid ← 0 → IDLE.
- ALU input registers hold their last value after the op completes and do not return to 0.
- Latency, FIFO empty and RspReady held 1:
  - Push at edge N gives RspValid=1 after edge N+3.
  - Back-to-back sustained throughput is one op per 4 cycles.
- Results are delivered strictly in request order. No result bits are modified; full DATA_WIDTH is passed through.
- Busy=1 from the push edge until the RESP handshake of the last queued op completes.

Test Plan:
- Reset and single add:
  - Stimulus: hold Rst_n=0 for 3 cycles, then push ctrl=0, A=4, B=9.
  - Expect: all outputs 0 during reset; RspResult=13, RspZero=0, RspCtrl=0, RspErr=0 exactly 3 edges after the push.
- Ordered burst:
  - Stimulus: push sub(9,2), mul(3,5), and(0x0000FFFF,0x00FF00FF), slt(15,7) back-to-back with RspReady=1.
  - Expect: responses 7, 15, 0x000000FF, 0 in order; last response has RspZero=1.
- Full/backpressure:
  - Stimulus: RspReady=0; push 6 xor ops.
  - Expect: ReqReady drops after FIFO_DEPTH+1 accepts (4 in FIFO, 1 in FSM). The first response holds stable for 10 cycles. Releasing RspReady drains all 5 accepted ops in order.
- Illegal code:
  - Stimulus: push ctrl=12, A=1, B=1.
  - Expect: RspErr=1, RspResult=0, RspZero=1, RspCtrl=12. The next legal op is unaffected.
- Reset mid-operation:
  - Stimulus: assert Rst_n=0 while in ISSUE with 2 ops queued.
  - Expect: RspValid=0 immediately (asynchronous); Busy=0; no stale responses after release.
- Pointer wrap:
  - Stimulus: 12 sequential ops, sll(7,2) followed by srl(31,2) alternating.
  - Expect: results 28, 7 alternating, all correct across FIFO wrap.
